// File: rtl/data_memory_hs.sv
// data_memory_hs: single-port data memory with valid/ready request handshake,
// registered 1-cycle response and an init sequencer that runs after reset.
// Parameters: WIDTH (word bits), DEPTH (words), INIT_MODE (0: zeros, 1: mem[i]=i).
// Optional feature macro: DMEM_WR_MASK_EN adds req_wmask (per-bit write enable).
// Ports:
//   clk, clr                 clock, synchronous active-high reset
//   req_valid, req_we        request present, 1 = write / 0 = read
//   req_addr, req_wdata      word address, write data
//   req_wmask                per-bit write enable (DMEM_WR_MASK_EN only)
//   req_ready                request can be accepted this cycle
//   rsp_valid, rsp_rdata     response pulse, read data (0 on write ack / error)
//   rsp_err                  accepted address was >= DEPTH
//   init_done                init sequence finished, held until next clr
module data_memory_hs #(
   parameter int  WIDTH     = 4,
   parameter int  DEPTH     = 16,
   parameter int  INIT_MODE = 1,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WIDTH-1:0]  req_wdata,
`ifdef DMEM_WR_MASK_EN
   input  logic [WIDTH-1:0]  req_wmask,
`endif
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [WIDTH-1:0]  rsp_rdata,
   output logic              rsp_err,
   output logic              init_done
);

   // init_idx is one bit wider than the address so it cannot wrap
   // when DEPTH is an exact power of two.
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);

   typedef enum logic {
      S_INIT,
      S_IDLE
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W:0]   init_idx;
   logic [WIDTH-1:0]  mem [DEPTH];

   logic              init_we;
   logic              acc;
   logic              addr_ok;
   logic              wr_en;
   logic [WIDTH-1:0]  init_val;
   logic [WIDTH-1:0]  wr_val;

   assign addr_ok  = {1'b0, req_addr} < DEPTH_W;
   assign init_val = (INIT_MODE != 0) ? WIDTH'(init_idx) : '0;
   assign wr_en    = acc & req_we & addr_ok;

   always_comb begin
`ifdef DMEM_WR_MASK_EN
      wr_val = (mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
`else
      wr_val = req_wdata;
`endif
   end

   always_comb begin
      state_nx = state;
      init_we  = 1'b0;
      acc      = 1'b0;
      unique case (state)
         S_INIT: begin
            init_we = 1'b1;
            if (init_idx == LAST) begin
               state_nx = S_IDLE;
            end
         end
         S_IDLE: begin
            acc = req_valid & req_ready;
         end
         default: begin
            state_nx = S_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= S_INIT;
         init_idx  <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nx;
         rsp_valid <= acc;
         rsp_err   <= acc & ~addr_ok;
         if (init_we) begin
            init_idx <= init_idx + 1'b1;
         end
         // Ready is registered: first visible after the last init write.
         if (init_we && state_nx == S_IDLE) begin
            init_done <= 1'b1;
            req_ready <= 1'b1;
         end
         if (acc) begin
            rsp_rdata <= (!req_we && addr_ok) ? mem[req_addr] : '0;
         end
      end
   end

   // Storage has no reset; it is left untouched while clr is held.
   always_ff @(posedge clk) begin
      if (!clr) begin
         if (init_we) begin
            mem[init_idx[ADDR_W-1:0]] <= init_val;
         end else if (wr_en) begin
            mem[req_addr] <= wr_val;
         end
      end
   end

endmodule

// File: tb/tb_data_memory_hs.sv
// tb_data_memory_hs: drives two data_memory_hs instances (16 words / ramp init,
// 12 words / zero init) with directed and random requests against a model.
module tb_data_memory_hs;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       valid = 1'b0;
   logic       we = 1'b0;
   logic [3:0] addr = '0;
   logic [3:0] wdata = '0;
   logic [3:0] wmask = '1;

   logic [1:0]      rdy;
   logic [1:0]      rv;
   logic [1:0]      err;
   logic [1:0]      done;
   logic [1:0][3:0] rd;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   data_memory_hs #(.WIDTH(4), .DEPTH(16), .INIT_MODE(1)) dut_a (
      .clk(clk), .clr(clr), .req_valid(valid), .req_we(we),
      .req_addr(addr), .req_wdata(wdata),
`ifdef DMEM_WR_MASK_EN
      .req_wmask(wmask),
`endif
      .req_ready(rdy[0]), .rsp_valid(rv[0]), .rsp_rdata(rd[0]),
      .rsp_err(err[0]), .init_done(done[0])
   );

   data_memory_hs #(.WIDTH(4), .DEPTH(12), .INIT_MODE(0)) dut_b (
      .clk(clk), .clr(clr), .req_valid(valid), .req_we(we),
      .req_addr(addr), .req_wdata(wdata),
`ifdef DMEM_WR_MASK_EN
      .req_wmask(wmask),
`endif
      .req_ready(rdy[1]), .rsp_valid(rv[1]), .rsp_rdata(rd[1]),
      .rsp_err(err[1]), .init_done(done[1])
   );

   // Behavioural model: count init cycles since reset; once DEPTH words are
   // written the memory serves one request per cycle.
   int         depth [2] = '{16, 12};
   int         mode  [2] = '{1, 0};
   logic [3:0] mm    [2][16];
   int         cnt   [2];
   bit         started = 1'b0;
   bit         e_rv  [2];
   bit         e_err [2];
   logic [3:0] e_rd  [2];

   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         if (clr) begin
            cnt[d]   = 0;
            e_rv[d]  = 1'b0;
            e_err[d] = 1'b0;
            e_rd[d]  = '0;
         end else if (cnt[d] < depth[d]) begin
            mm[d][cnt[d]] = (mode[d] != 0) ? 4'(cnt[d]) : 4'd0;
            cnt[d]++;
            e_rv[d]  = 1'b0;
            e_err[d] = 1'b0;
         end else if (valid) begin
            e_rv[d] = 1'b1;
            if (int'(addr) >= depth[d]) begin
               e_err[d] = 1'b1;
               e_rd[d]  = '0;
            end else if (we) begin
               e_err[d] = 1'b0;
               e_rd[d]  = '0;
`ifdef DMEM_WR_MASK_EN
               mm[d][addr] = (mm[d][addr] & ~wmask) | (wdata & wmask);
`else
               mm[d][addr] = wdata;
`endif
            end else begin
               e_err[d] = 1'b0;
               e_rd[d]  = mm[d][addr];
            end
         end else begin
            e_rv[d]  = 1'b0;
            e_err[d] = 1'b0;
         end
      end
      if (clr) started = 1'b1;
   endtask

   task automatic chk(input string nm, input int d,
                      input logic [3:0] act, input logic [3:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d @%0t: got %0h expected %0h",
                  nm, d, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      bit rdy_e;
      for (int d = 0; d < 2; d++) begin
         rdy_e = (cnt[d] >= depth[d]);
         chk("req_ready", d, 4'(rdy[d]), 4'(rdy_e));
         chk("init_done", d, 4'(done[d]), 4'(rdy_e));
         chk("rsp_valid", d, 4'(rv[d]), 4'(e_rv[d]));
         chk("rsp_err", d, 4'(err[d]), 4'(e_err[d]));
         chk("rsp_rdata", d, rd[d], e_rd[d]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (started) compare_all();
   endtask

   task automatic req(input bit v, input bit w, input int a,
                      input int dt, input int mk);
      valid = v;
      we    = w;
      addr  = 4'(a);
      wdata = 4'(dt);
      wmask = 4'(mk);
   endtask

   task automatic idle(input int n);
      req(0, 0, 0, 0, 15);
      repeat (n) step();
   endtask

   initial begin
      @(negedge clk);
      // reset 3 cycles, then a read held through init (must be ignored)
      clr = 1'b1;
      repeat (3) step();
      chk("reset_ready", 0, 4'(rdy[0]), 4'd0);
      chk("reset_rdata", 0, rd[0], 4'd0);
      clr = 1'b0;
      req(1, 0, 0, 0, 15);
      repeat (11) step();
      chk("ready_mid_init", 0, 4'(rdy[0]), 4'd0);
      repeat (5) step();
      chk("ready_after_16", 0, 4'(rdy[0]), 4'd1);
      idle(1);

      // ramp reads 0..15, one per cycle
      for (int i = 0; i < 16; i++) begin
         req(1, 0, i, 0, 15);
         step();
         if (i == 4) chk("zero_init_b", 1, rd[1], 4'd0);
         if (i == 13) chk("oob_err_b", 1, 4'(err[1]), 4'd1);
         chk("ramp_read", 0, rd[0], 4'(i));
      end

      // write then read same address, neighbour unaffected
      req(1, 1, 5, 11, 15);
      step();
      chk("wr_ack_rdata", 0, rd[0], 4'd0);
      req(1, 0, 5, 0, 15);
      step();
      chk("rd_after_wr", 0, rd[0], 4'd11);
      req(1, 0, 7, 0, 15);
      step();
      chk("rd_addr7", 0, rd[0], 4'd7);

      // out-of-range write on the 12-word instance
      req(1, 1, 14, 3, 15);
      step();
      chk("oob_wr_err", 1, 4'(err[1]), 4'd1);
      for (int i = 0; i < 12; i++) begin
         req(1, 0, i, 0, 15);
         step();
      end

`ifdef DMEM_WR_MASK_EN
      req(1, 1, 3, 4'b1100, 4'b0110);
      step();
      req(1, 0, 3, 0, 15);
      step();
      chk("mask_merge", 0, rd[0], 4'b0101);
      req(1, 1, 3, 4'b1010, 4'b0000);
      step();
      chk("mask_zero_ack", 0, 4'(rv[0]), 4'd1);
      req(1, 0, 3, 0, 15);
      step();
      chk("mask_zero_keep", 0, rd[0], 4'b0101);
`endif

      // clr mid-init, then clr after a write of 9 to addr 2
      idle(1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      idle(8);
      clr = 1'b1;
      step();
      clr = 1'b0;
      idle(16);
      req(1, 1, 2, 9, 15);
      step();
      req(1, 0, 2, 0, 15);
      step();
      chk("wr9_addr2", 0, rd[0], 4'd9);
      clr = 1'b1;
      req(1, 0, 2, 0, 15);
      step();
      chk("clr_drops_rsp", 0, 4'(rv[0]), 4'd0);
      clr = 1'b0;
      idle(16);
      req(1, 0, 2, 0, 15);
      step();
      chk("reinit_addr2", 0, rd[0], 4'd2);

      // random traffic with occasional reset
      for (int n = 0; n < 600; n++) begin
         clr = ($urandom_range(0, 79) == 0);
         req($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 15));
         step();
      end
      clr = 1'b0;
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
